alu_sequencer: RTL

Multi-cycle instruction sequencer that sits between instruction memory and the ALU control path. It fetches 32-bit instructions over a valid/request handshake and holds each one stable for the instruction decoder. It then starts the ALU, waits for completion under a watchdog, and commits the write-back. It owns the program counter and replaces the single-cycle `program_counter_inc` strobe with a full fetch/decode/execute/write-back state machine and a defined stopped state.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_sequencer_if.sv | 42 ++++
 rtl/seq_watchdog.sv | 38 +++
 rtl/alu_sequencer.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// ----------------------------------------------------------------------------
// alu_seq_pkg : shared types and constants for the ALU instruction sequencer
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_seq_pkg;

  localparam int INSTR_WIDTH   = 32;
  localparam int RETIRED_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    WRITEBACK = 3'd4,
    STOPPED   = 3'd5
  } seq_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_sequencer_if.sv
// ----------------------------------------------------------------------------
// alu_sequencer_if : control, instruction-memory and ALU handshake bundle
// Revision         : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface alu_sequencer_if #(
  parameter int PC_WIDTH = 16
);

  logic                                   start;
  logic                                   stop_req;
  logic                                   imem_req;
  logic [PC_WIDTH-1:0]                    imem_addr;
  logic                                   imem_valid;
  logic [alu_seq_pkg::INSTR_WIDTH-1:0]    imem_data;
  logic [alu_seq_pkg::INSTR_WIDTH-1:0]    instruction;
  logic                                   invalid_instruction;
  logic                                   alu_start;
  logic                                   alu_done;
  logic                                   alu_write_en;
  logic [PC_WIDTH-1:0]                    pc;
  logic                                   halted;
  logic                                   fault;
  logic [alu_seq_pkg::RETIRED_WIDTH-1:0]  retired;

  // master is the sequencer; slave is the memory/decoder/ALU environment
  modport master (
    input  start, stop_req, imem_valid, imem_data, invalid_instruction, alu_done,
    output imem_req, imem_addr, instruction, alu_start, alu_write_en,
           pc, halted, fault, retired
  );

  modport slave (
    output start, stop_req, imem_valid, imem_data, invalid_instruction, alu_done,
    input  imem_req, imem_addr, instruction, alu_start, alu_write_en,
           pc, halted, fault, retired
  );

endinterface

`default_nettype wire

// File: rtl/seq_watchdog.sv
// ----------------------------------------------------------------------------
// seq_watchdog : EXECUTE-phase cycle counter, flags the last permitted cycle
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module seq_watchdog #(
  parameter int EXEC_TIMEOUT = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW      = $clog2(EXEC_TIMEOUT + 1);
  localparam logic [CW-1:0] C_LIMIT = CW'(EXEC_TIMEOUT);
  localparam logic [CW-1:0] C_LAST  = CW'(EXEC_TIMEOUT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && (r_count != C_LIMIT)) begin
      r_count <= r_count + CW'(1);
    end
  end

  // The count reaches the limit at the end of this cycle.
  assign expired = enable && (r_count == C_LAST);

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ----------------------------------------------------------------------------
// alu_sequencer : fetch/decode/execute/write-back sequencer owning the PC
// Revision      : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int PC_WIDTH     = 16,
  parameter int RESET_PC     = 0,
  parameter int EXEC_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            resetn,
  alu_sequencer_if.master bus
);

  localparam logic [PC_WIDTH-1:0] C_RESET_PC = PC_WIDTH'(RESET_PC);

  seq_state_e                r_state;
  logic [PC_WIDTH-1:0]       r_pc;
  logic [INSTR_WIDTH-1:0]    r_instruction;
  logic [RETIRED_WIDTH-1:0]  r_retired;
  logic                      r_imem_req;
  logic                      r_alu_start;
  logic                      r_alu_write_en;
  logic                      r_halted;
  logic                      r_fault;

  logic                      w_wd_enable;
  logic                      w_wd_clear;
  logic                      w_wd_expired;

  // Any state other than EXECUTE holds the watchdog at zero, so it restarts on entry.
  assign w_wd_enable = (r_state == EXECUTE);
  assign w_wd_clear  = !w_wd_enable;

  seq_watchdog #(
    .EXEC_TIMEOUT (EXEC_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state        <= IDLE;
      r_pc           <= C_RESET_PC;
      r_instruction  <= '0;
      r_retired      <= '0;
      r_imem_req     <= 1'b0;
      r_alu_start    <= 1'b0;
      r_alu_write_en <= 1'b0;
      r_halted       <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      r_alu_start    <= 1'b0;
      r_alu_write_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.stop_req) begin
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (bus.imem_valid) begin
            r_instruction <= bus.imem_data;
            r_imem_req    <= 1'b0;
            r_state       <= DECODE;
          end
        end
        DECODE: begin
          if (bus.invalid_instruction) begin
            r_state  <= STOPPED;
            r_halted <= 1'b1;
            r_fault  <= 1'b0;
          end else begin
            r_state     <= EXECUTE;
            r_alu_start <= 1'b1;
          end
        end
        EXECUTE: begin
          // Completion takes priority over a timeout on the same cycle.
          if (bus.alu_done) begin
            r_state        <= WRITEBACK;
            r_alu_write_en <= 1'b1;
          end else if (w_wd_expired) begin
            r_state  <= STOPPED;
            r_halted <= 1'b1;
            r_fault  <= 1'b1;
          end
        end
        WRITEBACK: begin
          r_pc      <= r_pc + PC_WIDTH'(1);
          r_retired <= r_retired + RETIRED_WIDTH'(1);
          if (bus.stop_req) begin
            r_state <= IDLE;
          end else begin
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
          end
        end
        STOPPED: begin
          if (bus.start) begin
            r_state    <= FETCH;
            r_imem_req <= 1'b1;
            r_halted   <= 1'b0;
            r_fault    <= 1'b0;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_imem_req <= 1'b0;
          r_halted   <= 1'b0;
          r_fault    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req     = r_imem_req;
  assign bus.imem_addr    = r_pc;
  assign bus.instruction  = r_instruction;
  assign bus.alu_start    = r_alu_start;
  assign bus.alu_write_en = r_alu_write_en;
  assign bus.pc           = r_pc;
  assign bus.halted       = r_halted;
  assign bus.fault        = r_fault;
  assign bus.retired      = r_retired;

endmodule

`default_nettype wire
